// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - serial-in word framer: bit counting, shift strobes, valid/ready hand-off, overrun flag
module shift_seq #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_bit_valid,
   input  logic             i_bit,
   output logic             o_shift_clr,
   output logic             o_shift_en,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_busy,
   output logic             o_overrun
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int IW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FULL
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             overrun_q, overrun_d;
   logic             shift_clr, shift_en;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      overrun_d = overrun_q;
      shift_clr = 1'b0;
      shift_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               shift_clr = 1'b1;
               state_d   = SHIFT;
               cnt_d     = '0;
               data_d    = '0;
            end
         end
         SHIFT: begin
            // a restart wins over a bit arriving in the same cycle; that bit is lost
            if (i_start) begin
               shift_clr = 1'b1;
               cnt_d     = '0;
               data_d    = '0;
            end else if (i_bit_valid) begin
               shift_en                = 1'b1;
               data_d[cnt_q[IW-1:0]]   = i_bit;
               cnt_d                   = cnt_q + CW'(1);
               if (cnt_q == LAST_BIT) begin
                  state_d = FULL;
               end
            end
         end
         FULL: begin
            if (i_bit_valid) begin
               overrun_d = 1'b1;
            end
            if (i_ready) begin
               if (i_start) begin
                  shift_clr = 1'b1;
                  state_d   = SHIFT;
                  cnt_d     = '0;
                  data_d    = '0;
               end else begin
                  state_d = IDLE;
               end
            end else if (i_start) begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         data_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
      end
   end

   // strobes are suppressed while reset is applied so nothing downstream moves
   assign o_shift_clr = shift_clr & ~i_rst;
   assign o_shift_en  = shift_en & ~i_rst;
   assign o_data      = data_q;
   assign o_valid     = (state_q == FULL);
   assign o_busy      = (state_q != IDLE);
   assign o_overrun   = overrun_q;

   a_strobe_excl : assert property (@(posedge i_clk) !(o_shift_clr && o_shift_en));
   a_en_in_shift : assert property (@(posedge i_clk) o_shift_en |-> (state_q == SHIFT));

endmodule

// File: doc/shift_seq.md
# shift_seq

Sequencing controller for the serial-in shift datapath: frames one WIDTH-bit word from a serial bit stream, gates the shift-enable and clear strobes for the downstream shift register, and presents the assembled word on a valid/ready handshake to the core. It sits between a bit source and the forth_cpu fetch/IO logic. It owns word boundaries, bit counting, back-pressure and overrun detection, so the shift register itself stays a plain datapath.

## Interface
- WIDTH, 8, word length in bits; legal range 2..64.
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_start  input  1  begin a new word; one-cycle pulse.
- i_bit_valid  input  1  i_bit carries a bit this cycle.
- i_bit  input  1  serial data bit.
- o_shift_clr  output  1  clear strobe to the shift register.
- o_shift_en  output  1  shift-enable strobe to the shift register.
- o_data  output  WIDTH  assembled word, LSB = first bit received.
- o_valid  output  1  o_data holds a complete word.
- i_ready  input  1  consumer accepts the word.
- o_busy  output  1  a word is in progress or held.
- o_overrun  output  1  sticky error flag.

## Operation
- States: IDLE, SHIFT, FULL. Bit counter cnt has width $clog2(WIDTH+1).
- Reset (i_rst=1 at an edge): state IDLE, cnt 0, o_data 0, o_valid 0, o_overrun 0. Reset has priority over every other input, including mid-word and in FULL.
- o_busy = (state != IDLE). o_valid = (state == FULL). Both are decoded from registered state.
- IDLE
  - i_start accepted: o_shift_clr=1 in the same cycle (combinational). Next state SHIFT, cnt←0, o_data←0.
  - i_bit_valid is ignored; it does not set o_overrun.
- SHIFT
  - i_start has priority. It restarts the frame: o_shift_clr=1, cnt←0, o_data←0, and any bit arriving that cycle is dropped (o_shift_en=0).
  - Otherwise, when i_bit_valid=1: o_shift_en=1 (combinational, aligned with i_bit), o_data[cnt]←i_bit, cnt←cnt+1.
  - If that accepted bit has cnt==WIDTH-1, the next state is FULL.
- FULL
  - o_data is frozen and cnt holds at WIDTH; o_shift_en=0 and o_shift_clr=0.
  - i_ready=1 → IDLE. If i_start=1 in the same cycle, go directly to SHIFT with a clear strobe (back-to-back words).
  - i_bit_valid=1 while in FULL sets o_overrun and discards the bit.
  - i_start=1 without i_ready sets o_overrun and is ignored.
- o_overrun clears only on reset.
- o_data holds the last delivered word through IDLE until the next accepted i_start.
- o_shift_en is never high outside SHIFT. o_shift_clr and o_shift_en are never high in the same cycle.

## Timing
- i_start in cycle 0 (IDLE): o_shift_clr high in cycle 0, o_busy high from cycle 1. The first bit can be accepted in cycle 1.
- Bits on consecutive cycles 1..WIDTH give o_valid high from cycle WIDTH+1. Latency from the last accepted bit to o_valid is 1 cycle.
- Gaps in i_bit_valid stall the counter without penalty.
- Handshake: the transfer happens on the edge where o_valid=1 and i_ready=1. o_valid drops on the following cycle unless a back-to-back start re-enters SHIFT, in which case o_valid also drops.
- i_ready while not in FULL has no effect.
- Minimum word period with back-to-back starts: WIDTH+1 cycles.

## Test plan
- Reset, then i_start, then bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles (WIDTH=8) → o_valid high 1 cycle after the last bit, o_data=8'h4D, o_shift_en pulsed exactly 8 times, o_shift_clr pulsed once.
- Same word with i_bit_valid asserted every other cycle and i_ready held low for 5 cycles after o_valid → o_data stable 8'h4D throughout FULL. o_valid falls the cycle after i_ready=1, with o_overrun=0.
- In FULL, drive i_bit_valid=1 for one cycle → o_overrun=1 and stays 1 through later words. o_data is unchanged. Then i_rst=1 → o_overrun=0.
- After 3 bits (1,1,1), pulse i_start together with i_bit_valid → that bit is dropped and cnt restarts. Bits 0x00 follow and the result is o_data=8'h00.
- Hold i_ready=1 and pulse i_start on the handshake cycle → SHIFT entered immediately. The second word 8'hA5 is delivered WIDTH+1 cycles after the first.
- Assert i_rst mid-word after 5 bits → next cycle all outputs are 0 and state IDLE. Bits without a subsequent i_start produce no o_shift_en.
